// File: rtl/execute_memory_register.sv
// execute_memory_register: EX/MEM pipeline register with {N,Z,V} flags, stall/flush, sticky halt; optional bubble_cnt output when EXMEM_BUBBLE_CNT_EN is defined
module execute_memory_register #(
  parameter int DATA_W = 16,
  parameter logic [2:0] FLAG_RST = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] next_pc,
  input  logic [3:0]        write_reg,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              hlt,
  input  logic              pcs,
  input  logic [2:0]        flag_in,
  input  logic [2:0]        flag_wen,
  output logic [DATA_W-1:0] alu_result_em,
  output logic [DATA_W-1:0] store_data_em,
  output logic [DATA_W-1:0] next_pc_em,
  output logic [3:0]        write_reg_em,
  output logic              reg_write_em,
  output logic              mem_read_em,
  output logic              mem_write_em,
  output logic              mem_to_reg_em,
  output logic              hlt_em,
  output logic              pcs_em,
  output logic              valid_em,
  output logic [2:0]        flags,
`ifdef EXMEM_BUBBLE_CNT_EN
  output logic [15:0]       bubble_cnt,
`endif
  output logic              halted
);
  logic hold, upd, load;
  assign hold = halted | (valid_em & hlt_em);
  assign upd  = ~hold & (flush | ~stall);
  assign load = ex_valid & ~flush;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_em <= '0;
      store_data_em <= '0;
      next_pc_em    <= '0;
      write_reg_em  <= '0;
      reg_write_em  <= 1'b0;
      mem_read_em   <= 1'b0;
      mem_write_em  <= 1'b0;
      mem_to_reg_em <= 1'b0;
      hlt_em        <= 1'b0;
      pcs_em        <= 1'b0;
      valid_em      <= 1'b0;
      flags         <= FLAG_RST;
      halted        <= 1'b0;
    end else begin
      halted <= hold;
      if (upd) begin
        alu_result_em <= load ? alu_result : '0;
        store_data_em <= load ? store_data : '0;
        next_pc_em    <= load ? next_pc : '0;
        write_reg_em  <= load ? write_reg : '0;
        reg_write_em  <= load & reg_write;
        mem_read_em   <= load & mem_read;
        mem_write_em  <= load & mem_write;
        mem_to_reg_em <= load & mem_to_reg;
        hlt_em        <= load & hlt;
        pcs_em        <= load & pcs;
        valid_em      <= load;
        flags         <= load ? (flag_wen & flag_in) | (~flag_wen & flags) : flags;
      end
    end
  end
`ifdef EXMEM_BUBBLE_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bubble_cnt <= '0;
    else if (upd && !load && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_execute_memory_register.sv
// tb_execute_memory_register: directed self-checking bench for execute_memory_register
module tb_execute_memory_register;
  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid;
  logic [15:0] alu_result, store_data, next_pc;
  logic [3:0]  write_reg;
  logic        reg_write, mem_read, mem_write, mem_to_reg, hlt, pcs;
  logic [2:0]  flag_in, flag_wen;
  logic [15:0] alu_result_em, store_data_em, next_pc_em;
  logic [3:0]  write_reg_em;
  logic        reg_write_em, mem_read_em, mem_write_em, mem_to_reg_em, hlt_em, pcs_em;
  logic        valid_em, halted;
  logic [2:0]  flags;
`ifdef EXMEM_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  execute_memory_register dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .alu_result(alu_result), .store_data(store_data), .next_pc(next_pc),
    .write_reg(write_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .hlt(hlt), .pcs(pcs),
    .flag_in(flag_in), .flag_wen(flag_wen),
    .alu_result_em(alu_result_em), .store_data_em(store_data_em), .next_pc_em(next_pc_em),
    .write_reg_em(write_reg_em), .reg_write_em(reg_write_em), .mem_read_em(mem_read_em),
    .mem_write_em(mem_write_em), .mem_to_reg_em(mem_to_reg_em), .hlt_em(hlt_em),
    .pcs_em(pcs_em), .valid_em(valid_em), .flags(flags),
`ifdef EXMEM_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .halted(halted)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic pulse_reset();
    #1 rst = 1'b0;
    #1 check("async_rst_valid", valid_em, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    rst = 1'b0; stall = 0; flush = 0; ex_valid = 1;
    alu_result = 16'hFFFF; store_data = 16'hFFFF; next_pc = 16'hFFFF; write_reg = 4'hF;
    reg_write = 1; mem_read = 1; mem_write = 1; mem_to_reg = 1; hlt = 0; pcs = 1;
    flag_in = 3'b111; flag_wen = 3'b111;
    step();
    step();
    check("rst_alu", alu_result_em, 0);
    check("rst_wr", write_reg_em, 0);
    check("rst_valid", valid_em, 0);
    check("rst_ctrl", {reg_write_em, mem_read_em, mem_write_em, mem_to_reg_em, hlt_em, pcs_em}, 0);
    check("rst_flags", flags, 3'b000);
    check("rst_halted", halted, 0);
    rst = 1'b1;
    alu_result = 16'h1234; store_data = 16'h0042; next_pc = 16'h0010; write_reg = 4'h5;
    reg_write = 1; mem_read = 0; mem_write = 0; mem_to_reg = 0; pcs = 0; flag_wen = 3'b000;
    step();
    check("load_alu", alu_result_em, 16'h1234);
    check("load_store", store_data_em, 16'h0042);
    check("load_pc", next_pc_em, 16'h0010);
    check("load_wr", write_reg_em, 4'h5);
    check("load_regw", reg_write_em, 1);
    check("load_memr", mem_read_em, 0);
    check("load_valid", valid_em, 1);
    check("load_flags", flags, 3'b000);
    alu_result = 16'hAAAA;
    step();
    check("pre_stall", alu_result_em, 16'hAAAA);
    stall = 1; alu_result = 16'h5555; flag_wen = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", alu_result_em, 16'hAAAA);
      check("stall_flags", flags, 3'b000);
    end
    stall = 0; flag_wen = 3'b000;
    step();
    check("unstall_load", alu_result_em, 16'h5555);
    stall = 1; flush = 1; mem_write = 1; flag_wen = 3'b111;
    step();
    check("flush_valid", valid_em, 0);
    check("flush_memw", mem_write_em, 0);
    check("flush_alu", alu_result_em, 0);
    check("flush_wr", write_reg_em, 0);
    check("flush_flags", flags, 3'b000);
    stall = 0; flush = 0; mem_write = 0; flag_in = 3'b111; flag_wen = 3'b010;
    step();
    check("flag_partial", flags, 3'b010);
    flush = 1;
    step();
    check("flag_flushed", flags, 3'b010);
    flush = 0; flag_in = 3'b101; flag_wen = 3'b101;
    step();
    check("flag_write2", flags, 3'b111);
    flag_in = 3'b000; flag_wen = 3'b111; ex_valid = 0;
    step();
    check("flag_invalid", flags, 3'b111);
    check("bubble_valid", valid_em, 0);
    flag_wen = 3'b000;
`ifdef EXMEM_BUBBLE_CNT_EN
    pulse_reset();
    ex_valid = 0;
    for (int i = 0; i < 5; i++) step();
    stall = 1;
    for (int i = 0; i < 2; i++) step();
    flush = 1;
    step();
    check("bubble_cnt", bubble_cnt, 6);
    stall = 0; flush = 0;
`endif
    pulse_reset();
    ex_valid = 1; hlt = 1; alu_result = 16'h0077;
    step();
    check("hlt_em", hlt_em, 1);
    check("hlt_valid", valid_em, 1);
    check("hlt_not_yet", halted, 0);
    hlt = 0; alu_result = 16'hBEEF;
    step();
    check("halted_set", halted, 1);
    check("halt_alu_hold", alu_result_em, 16'h0077);
    check("halt_hlt_hold", hlt_em, 1);
    flush = 1;
    step();
    check("halt_flush_ign", valid_em, 1);
    check("halt_alu_hold2", alu_result_em, 16'h0077);
    flush = 0;
    #2 rst = 1'b0;
    #1;
    check("arst_halted", halted, 0);
    check("arst_hlt", hlt_em, 0);
    check("arst_alu", alu_result_em, 0);
    check("arst_valid", valid_em, 0);
    check("arst_flags", flags, 3'b000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
